// File: rtl/ram_be_clr.sv
// ram_be_clr: single-port synchronous RAM with per-byte write enables,
// a registered read port with a one-cycle valid flag, and a hardware
// clear sweep that fills every word with CLEAR_VALUE after reset.
//
// Optional feature macro: RAM_WR_FWD_EN
//   defined   -> write-first: a read and a write on the same edge return the
//                merged word (new bytes on enabled lanes, old bytes elsewhere)
//   undefined -> read-first: the same case returns the word stored before
//                the write; the write still completes.
module ram_be_clr #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24,
    parameter int BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic                             write_enable,
    input  logic                             read_enable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_valid,
    output logic                             busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    last_word;

    // The word currently stored at the request address (pre-write view).
    assign rd_word   = mem[address];
    assign last_word = (counter == ADDR_WIDTH'(DEPTH - 1));

`ifdef RAM_WR_FWD_EN
    logic [DATA_WIDTH-1:0] merged;

    // Stored word with the enabled lanes replaced by the incoming write data.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end
`endif

    // Memory array: clear sweep writes whole words, traffic writes per lane; nothing on reset edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[counter] <= CLEAR_VALUE;
            end else if (write_enable) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_en[i]) begin
                        mem[address][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Control FSM with registered busy, read data and valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            counter    <= '0;
            busy       <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    data_valid <= 1'b0;
                    counter    <= counter + ADDR_WIDTH'(1);
                    if (last_word) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy       <= 1'b0;
                    data_valid <= read_enable;
                    if (read_enable) begin
`ifdef RAM_WR_FWD_EN
                        data_out <= write_enable ? merged : rd_word;
`else
                        data_out <= rd_word;
`endif
                    end
                end
                default: begin
                    state      <= CLEAR;
                    counter    <= '0;
                    busy       <= 1'b1;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_be_clr.sv
// Directed self-checking bench for ram_be_clr (ADDR_WIDTH=4, CLEAR_VALUE=5a5a5a).
module tb_ram_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  address;
    logic        write_enable;
    logic        read_enable;
    logic [2:0]  byte_en;
    logic [23:0] data_in;
    logic [23:0] data_out;
    logic        data_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] CV = 24'h5a5a5a;

    ram_be_clr #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (24),
        .BYTE_WIDTH (8),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .byte_en     (byte_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy falls; checks data_valid stays low meanwhile.
    task automatic wait_sweep(input string tag);
        int  n;
        bit  dv_seen;
        n = 0;
        dv_seen = 0;
        while (n < 40) begin
            step();
            n++;
            if (data_valid !== 1'b0) dv_seen = 1;
            if (busy === 1'b0) break;
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        chk({tag, "_busy_cycles"}, n, 16);
        chk({tag, "_dv_low"}, {31'd0, dv_seen}, 0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            address     = 4'(a);
            read_enable = 1'b1;
            step();
            chk({tag, "_data"}, {8'd0, data_out}, {8'd0, CV});
            chk({tag, "_valid"}, {31'd0, data_valid}, 1);
        end
        read_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; address = '0; write_enable = 1'b0; read_enable = 1'b0;
        byte_en = '0; data_in = '0;

        // reset state
        step();
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_valid", {31'd0, data_valid}, 0);
        chk("rst_data", {8'd0, data_out}, 0);

        // sweep with a write/read request held that must be ignored
        rst = 1'b0;
        address = 4'd5; data_in = 24'h000246; byte_en = 3'b111;
        write_enable = 1'b1; read_enable = 1'b1;
        wait_sweep("sweep1");
        read_all("clear1");

        // byte lanes
        address = 4'd3; write_enable = 1'b1;
        data_in = 24'h000afc; byte_en = 3'b111;
        step();
        chk("wr_no_valid", {31'd0, data_valid}, 0);
        data_in = 24'hffffff; byte_en = 3'b100;
        step();
        write_enable = 1'b0; read_enable = 1'b1;
        step();
        chk("lane_data", {8'd0, data_out}, 32'h00ff0afc);
        chk("lane_valid", {31'd0, data_valid}, 1);

        // hold
        address = 4'd2;
        step();
        chk("hold_rd", {8'd0, data_out}, {8'd0, CV});
        read_enable = 1'b0; address = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", {8'd0, data_out}, {8'd0, CV});
            chk("hold_valid", {31'd0, data_valid}, 0);
        end

        // read during write, full word
        address = 4'd7; write_enable = 1'b1; byte_en = 3'b111; data_in = 24'h00b031;
        step();
        data_in = 24'hc10dd3; read_enable = 1'b1;
        step();
`ifdef RAM_WR_FWD_EN
        chk("rdw_full", {8'd0, data_out}, 32'h00c10dd3);
`else
        chk("rdw_full", {8'd0, data_out}, 32'h0000b031);
`endif
        chk("rdw_valid", {31'd0, data_valid}, 1);
        write_enable = 1'b0;
        step();
        chk("rdw_after", {8'd0, data_out}, 32'h00c10dd3);

        // read during write, one lane
        write_enable = 1'b1; byte_en = 3'b001; data_in = 24'h0000aa;
        step();
`ifdef RAM_WR_FWD_EN
        chk("rdw_lane", {8'd0, data_out}, 32'h00c10daa);
`else
        chk("rdw_lane", {8'd0, data_out}, 32'h00c10dd3);
`endif
        write_enable = 1'b0;
        step();
        chk("rdw_lane_after", {8'd0, data_out}, 32'h00c10daa);

        // byte_en = 0 leaves the word unchanged
        read_enable = 1'b0; write_enable = 1'b1; byte_en = 3'b000; data_in = 24'h123456;
        step();
        write_enable = 1'b0; read_enable = 1'b1;
        step();
        chk("be0_data", {8'd0, data_out}, 32'h00c10daa);
        read_enable = 1'b0;

        // reset mid-sweep
        rst = 1'b1;
        step();
        chk("rst2_data", {8'd0, data_out}, 0);
        chk("rst2_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        step();
        chk("rst3_busy", {31'd0, busy}, 1);
        chk("rst3_valid", {31'd0, data_valid}, 0);
        rst = 1'b0;
        wait_sweep("sweep2");
        read_all("clear2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
